ulpb_lc_tx_arbiter: RTL and testbench

//  Shares one ulpb node TX request port among NUM_REQ layer controllers (LCs).

---
 rtl/ulpb_lc_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ulpb_lc_tx_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpb_lc_tx_arbiter.sv
// Shares one ulpb node TX request port among NUM_REQ layer controllers and routes completions back.
// Define ULPB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round robin.
module ulpb_lc_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int OWN_DEPTH  = 8
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [NUM_REQ-1:0]             LC_REQ,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  LC_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  LC_DATA,
    output logic [NUM_REQ-1:0]             LC_ACK,
    output logic [NUM_REQ-1:0]             LC_TX_SUCCESS,
    output logic [NUM_REQ-1:0]             LC_TX_FAIL,
    input  logic [NUM_REQ-1:0]             LC_TX_ACK,
    output logic [ADDR_WIDTH-1:0]          NODE_ADDR,
    output logic [DATA_WIDTH-1:0]          NODE_DATA,
    output logic                           NODE_REQ,
    input  logic                           NODE_ACK,
    input  logic                           NODE_TX_SUCCESS,
    input  logic                           NODE_TX_FAIL,
    output logic                           NODE_TX_ACK,
    output logic [IDX_WIDTH-1:0]           GRANT_IDX,
    output logic                           ORPHAN
);
    // LC side and node side both use 4-phase valid/ready: a request stays high until its
    // acknowledge rises, then drops; the acknowledge drops only after the request is low.
    localparam int PTR_W = $clog2(OWN_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NREQ = 2'd1,
        S_LACK = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [IDX_WIDTH-1:0] win_idx;
    logic [IDX_WIDTH-1:0] cand_idx;
    logic                 win_vld;
    logic                 grant;
    int                   cand;

    logic [IDX_WIDTH-1:0] owner_q [OWN_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count;
    logic                 q_full;
    logic                 q_empty;
    logic                 push;
    logic                 pop;
    logic [IDX_WIDTH-1:0] head;

    logic                 status;
    logic                 status_q;
    logic                 owned_q;
    logic                 stat_owned;

    assign q_full  = (count == (PTR_W+1)'(OWN_DEPTH));
    assign q_empty = (count == '0);
    assign grant   = (state == S_IDLE) && win_vld && !q_full;
    assign push    = (state == S_NREQ) && NODE_ACK;
    assign head    = owner_q[rd_ptr];

    // Winner search starts at rr_ptr and wraps; with fixed priority rr_ptr is tied to 0.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_WIDTH'(cand);
            if (!win_vld && LC_REQ[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

`ifdef ULPB_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) rr_ptr <= '0;
        else if (grant) rr_ptr <= (win_idx == IDX_WIDTH'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
    end
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant) state_nxt = S_NREQ;
            S_NREQ:  if (NODE_ACK) state_nxt = S_LACK;
            S_LACK:  if (!LC_REQ[GRANT_IDX] && !NODE_ACK) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        NODE_REQ  = 1'b0;
        NODE_ADDR = '0;
        NODE_DATA = '0;
        LC_ACK    = '0;
        if (state == S_NREQ) begin
            NODE_REQ  = 1'b1;
            NODE_ADDR = LC_ADDR[GRANT_IDX*ADDR_WIDTH +: ADDR_WIDTH];
            NODE_DATA = LC_DATA[GRANT_IDX*DATA_WIDTH +: DATA_WIDTH];
        end
        if (state == S_LACK) LC_ACK[GRANT_IDX] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)     GRANT_IDX <= '0;
        else if (grant) GRANT_IDX <= win_idx;
    end

    always_ff @(posedge CLK) begin
        if (push) owner_q[wr_ptr] <= GRANT_IDX;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Ownership of a status episode is decided when it starts, so a push landing while an
    // orphan status is still high cannot be popped by that orphan's falling edge.
    assign status     = NODE_TX_SUCCESS | NODE_TX_FAIL;
    assign stat_owned = status_q ? owned_q : !q_empty;
    assign pop        = status_q && !status && owned_q;

    always_comb begin
        LC_TX_SUCCESS = '0;
        LC_TX_FAIL    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_owned && head == IDX_WIDTH'(i)) begin
                LC_TX_SUCCESS[i] = NODE_TX_SUCCESS;
                LC_TX_FAIL[i]    = NODE_TX_FAIL;
            end
        end
        NODE_TX_ACK = stat_owned ? LC_TX_ACK[head] : status;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            status_q <= 1'b0;
            owned_q  <= 1'b0;
            ORPHAN   <= 1'b0;
        end else begin
            status_q <= status;
            if (status) owned_q <= stat_owned;
            if (status && !stat_owned) ORPHAN <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ulpb_lc_tx_arbiter.sv
// Directed bench for ulpb_lc_tx_arbiter: grants, round robin, completion routing, full queue, orphans, reset.
module tb_ulpb_lc_tx_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int IDX_WIDTH  = 2;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int OWN_DEPTH  = 8;

    logic                          CLK = 1'b0;
    logic                          RESET = 1'b0;
    logic [NUM_REQ-1:0]            LC_REQ = '0;
    logic [NUM_REQ*ADDR_WIDTH-1:0] LC_ADDR;
    logic [NUM_REQ*DATA_WIDTH-1:0] LC_DATA;
    logic [NUM_REQ-1:0]            LC_ACK;
    logic [NUM_REQ-1:0]            LC_TX_SUCCESS;
    logic [NUM_REQ-1:0]            LC_TX_FAIL;
    logic [NUM_REQ-1:0]            LC_TX_ACK = '0;
    logic [ADDR_WIDTH-1:0]         NODE_ADDR;
    logic [DATA_WIDTH-1:0]         NODE_DATA;
    logic                          NODE_REQ;
    logic                          NODE_ACK = 1'b0;
    logic                          NODE_TX_SUCCESS = 1'b0;
    logic                          NODE_TX_FAIL = 1'b0;
    logic                          NODE_TX_ACK;
    logic [IDX_WIDTH-1:0]          GRANT_IDX;
    logic                          ORPHAN;

    int n_checks = 0;
    int n_fail   = 0;

    ulpb_lc_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .IDX_WIDTH(IDX_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .OWN_DEPTH(OWN_DEPTH)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .LC_REQ(LC_REQ), .LC_ADDR(LC_ADDR), .LC_DATA(LC_DATA), .LC_ACK(LC_ACK),
        .LC_TX_SUCCESS(LC_TX_SUCCESS), .LC_TX_FAIL(LC_TX_FAIL), .LC_TX_ACK(LC_TX_ACK),
        .NODE_ADDR(NODE_ADDR), .NODE_DATA(NODE_DATA), .NODE_REQ(NODE_REQ), .NODE_ACK(NODE_ACK),
        .NODE_TX_SUCCESS(NODE_TX_SUCCESS), .NODE_TX_FAIL(NODE_TX_FAIL), .NODE_TX_ACK(NODE_TX_ACK),
        .GRANT_IDX(GRANT_IDX), .ORPHAN(ORPHAN)
    );

    // Clock and reset
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input int lc);
        return ADDR_WIDTH'(8'hA0 + lc);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] data_of(input int lc);
        return DATA_WIDTH'(32'hC0DE_0000 + lc * 32'h0001_0011);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Each cycle window starts 2ns after the rising edge; inputs are driven there.
    task automatic next_cycle();
        @(posedge CLK);
        #2;
    endtask

    task automatic reset_dut();
        RESET = 1'b0;
        LC_REQ = '0; LC_TX_ACK = '0;
        NODE_ACK = 1'b0; NODE_TX_SUCCESS = 1'b0; NODE_TX_FAIL = 1'b0;
        next_cycle();
        next_cycle();
        RESET = 1'b1;
        next_cycle();
    endtask

    // Node side of one transfer: wait for NODE_REQ, ack it, LC drops its request on LC_ACK.
    task automatic transfer(input int exp_lc);
        int w;
        w = 0;
        while (!NODE_REQ && w < 20) begin
            next_cycle();
            w++;
        end
        check_eq("nreq_seen", 64'(NODE_REQ), 64'd1);
        check_eq("grant_idx", 64'(GRANT_IDX), 64'(exp_lc));
        check_eq("node_addr", 64'(NODE_ADDR), 64'(addr_of(exp_lc)));
        check_eq("node_data", 64'(NODE_DATA), 64'(data_of(exp_lc)));
        NODE_ACK = 1'b1;
        next_cycle();
        check_eq("lc_ack", 64'(LC_ACK), 64'(4'b0001 << exp_lc));
        check_eq("nreq_low", 64'(NODE_REQ), 64'd0);
        LC_REQ[exp_lc] = 1'b0;
        NODE_ACK = 1'b0;
        next_cycle();
        check_eq("lc_ack_clr", 64'(LC_ACK), 64'd0);
    endtask

    // One completion from the node; exp_vec is the LC it must reach (0 = orphan).
    task automatic complete(input logic success, input logic [NUM_REQ-1:0] exp_vec);
        NODE_TX_SUCCESS = success;
        NODE_TX_FAIL    = !success;
        #1;
        check_eq("tx_success_route", 64'(LC_TX_SUCCESS), success ? 64'(exp_vec) : 64'd0);
        check_eq("tx_fail_route", 64'(LC_TX_FAIL), success ? 64'd0 : 64'(exp_vec));
        check_eq("tx_ack_pre", 64'(NODE_TX_ACK), (exp_vec == '0) ? 64'd1 : 64'd0);
        LC_TX_ACK = exp_vec;
        #1;
        check_eq("tx_ack_fwd", 64'(NODE_TX_ACK), 64'd1);
        next_cycle();
        NODE_TX_SUCCESS = 1'b0;
        NODE_TX_FAIL    = 1'b0;
        LC_TX_ACK       = '0;
        next_cycle();
    endtask

    initial begin
        int order [5];
`ifdef ULPB_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            LC_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_of(i);
            LC_DATA[i*DATA_WIDTH +: DATA_WIDTH] = data_of(i);
        end

        // Reset state
        reset_dut();
        check_eq("rst_node_req", 64'(NODE_REQ), 64'd0);
        check_eq("rst_node_addr", 64'(NODE_ADDR), 64'd0);
        check_eq("rst_lc_ack", 64'(LC_ACK), 64'd0);
        check_eq("rst_grant", 64'(GRANT_IDX), 64'd0);
        check_eq("rst_orphan", 64'(ORPHAN), 64'd0);
        check_eq("rst_tx_ack", 64'(NODE_TX_ACK), 64'd0);

        // Single requester LC2, one-cycle request latency, then its completion
        LC_REQ = 4'b0100;
        #1;
        check_eq("lat_n", 64'(NODE_REQ), 64'd0);
        next_cycle();
        check_eq("lat_n1", 64'(NODE_REQ), 64'd1);
        transfer(2);
        complete(1'b1, 4'b0100);
        complete(1'b1, 4'b0000);
        check_eq("orphan_after_empty", 64'(ORPHAN), 64'd1);

        // All four requesting, each re-raises after its ack
        reset_dut();
        LC_REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            transfer(order[k]);
            LC_REQ[order[k]] = 1'b1;
        end
        LC_REQ = '0;

        // Completion routing: grants 1 then 3, success to LC1, fail to LC3
        reset_dut();
        LC_REQ = 4'b0010;
        transfer(1);
        LC_REQ = 4'b1000;
        transfer(3);
        complete(1'b1, 4'b0010);
        complete(1'b0, 4'b1000);
        check_eq("route_no_orphan", 64'(ORPHAN), 64'd0);

        // LC drops its request early: message still goes out, LC_ACK pulses one cycle
        LC_REQ = 4'b1000;
        next_cycle();
        check_eq("early_nreq", 64'(NODE_REQ), 64'd1);
        check_eq("early_grant", 64'(GRANT_IDX), 64'd3);
        LC_REQ = '0;
        NODE_ACK = 1'b1;
        next_cycle();
        check_eq("early_lc_ack", 64'(LC_ACK), 64'b1000);
        NODE_ACK = 1'b0;
        next_cycle();
        check_eq("early_lc_ack_pulse", 64'(LC_ACK), 64'd0);
        check_eq("early_idle", 64'(NODE_REQ), 64'd0);
        complete(1'b1, 4'b1000);

        // Fill owner queue with 8 LC0 grants; 9th request (LC2) must wait
        reset_dut();
        for (int k = 0; k < OWN_DEPTH; k++) begin
            LC_REQ[0] = 1'b1;
            transfer(0);
        end
        LC_REQ = 4'b0100;
        repeat (5) next_cycle();
        check_eq("full_hold", 64'(NODE_REQ), 64'd0);
        complete(1'b1, 4'b0001);
        next_cycle();
        check_eq("full_release_nreq", 64'(NODE_REQ), 64'd1);
        check_eq("full_release_grant", 64'(GRANT_IDX), 64'd2);
        check_eq("full_release_addr", 64'(NODE_ADDR), 64'(addr_of(2)));

        // Pop and push on the same edge
        NODE_TX_SUCCESS = 1'b1;
        #1;
        check_eq("pp_route", 64'(LC_TX_SUCCESS), 64'b0001);
        next_cycle();
        NODE_TX_SUCCESS = 1'b0;
        NODE_ACK = 1'b1;
        next_cycle();
        check_eq("pp_lc_ack", 64'(LC_ACK), 64'b0100);
        LC_REQ = '0;
        NODE_ACK = 1'b0;
        next_cycle();

        // Six LC0 entries remain, then LC2, then the queue is empty
        for (int k = 0; k < OWN_DEPTH - 2; k++) complete(1'b1, 4'b0001);
        check_eq("drain_no_orphan", 64'(ORPHAN), 64'd0);
        complete(1'b0, 4'b0100);
        check_eq("drain_no_orphan2", 64'(ORPHAN), 64'd0);
        complete(1'b1, 4'b0000);
        check_eq("orphan_sticky", 64'(ORPHAN), 64'd1);

        // Reset pulse while in NREQ
        LC_REQ = 4'b0010;
        next_cycle();
        check_eq("mid_nreq", 64'(NODE_REQ), 64'd1);
        RESET = 1'b0;
        #1;
        check_eq("mid_rst_nreq", 64'(NODE_REQ), 64'd0);
        check_eq("mid_rst_orphan", 64'(ORPHAN), 64'd0);
        check_eq("mid_rst_grant", 64'(GRANT_IDX), 64'd0);
        LC_REQ = '0;
        next_cycle();
        RESET = 1'b1;
        next_cycle();
        complete(1'b1, 4'b0000);
        check_eq("mid_rst_orphan_after", 64'(ORPHAN), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
